if_id_pipe_reg: RTL

- IF/ID pipeline register for the RISCV64 core, between fetch (PC/IMEM) and decode.
- Consumes the control-stall request (IF_ID_cstall) and the load-use hold (IF_ID_dstall). Inserts NOP bubbles and freezes fetch until the branch in EX resolves.
- Drives the decode-side PC/instruction/valid and the fetch-hold back to the PC unit.

---
 rtl/if_id_pipe_reg_pkg.sv | 16 +
 rtl/if_id_wait_ctr.sv | 33 +++
 rtl/if_id_pipe_reg.sv | 114 +++++++++++
 3 files changed

// File: rtl/if_id_pipe_reg_pkg.sv
// Shared constants and FSM state encoding for the IF/ID pipeline register.
// Imported by if_id_pipe_reg and if_id_wait_ctr.
package if_id_pipe_reg_pkg;

  localparam int          DEF_XLEN     = 64;
  localparam int          DEF_ILEN     = 32;
  localparam int          DEF_MAX_WAIT = 3;
  localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0013;  // addi x0,x0,0
  localparam int          PERF_W       = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } if_id_state_e;

endpackage

// File: rtl/if_id_wait_ctr.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for the WAIT bubble count and, optionally, the bubble perf counter.
module if_id_wait_ctr
  import if_id_pipe_reg_pkg::*;
#(
  parameter int unsigned W   = 2,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == MAX);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)               cnt_d = '0;
    else if (inc_i && !sat_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: captures fetch, inserts NOP bubbles on control stalls
// and holds fetch until the branch resolves. IF_ID_PERF_CNT_EN adds bubble_total.
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int          XLEN     = DEF_XLEN,
  parameter int          ILEN     = DEF_ILEN,
  parameter int          MAX_WAIT = DEF_MAX_WAIT,
  parameter logic [ILEN-1:0] NOP_INSN = DEF_NOP_INSN[ILEN-1:0]
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_valid,
  input  logic [XLEN-1:0]               pc_in,
  input  logic [ILEN-1:0]               instr_in,
  input  logic                          IF_ID_cstall,
  input  logic                          IF_ID_dstall,
  input  logic                          br_resolved,
  input  logic                          br_taken,
  output logic [XLEN-1:0]               pc_out,
  output logic [XLEN-1:0]               pc_plus4_out,
  output logic [ILEN-1:0]               instr_out,
  output logic                          valid_out,
  output logic                          fetch_hold,
  output logic [$clog2(MAX_WAIT+1)-1:0] wait_cnt
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]             bubble_total
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  if_id_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            valid_q;
  logic            wait_sat;
  logic            in_wait;

  // Taken and not-taken both leave WAIT the same way: the bubble already
  // covers the wrong-path slot, so the direction itself is not needed here.
  logic unused_br_taken;
  assign unused_br_taken = br_taken;

  assign in_wait = (state_q == ST_WAIT);

  if_id_wait_ctr #(
    .W   (CW),
    .MAX (CW'(MAX_WAIT))
  ) u_wait_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_wait || br_resolved || wait_sat),
    .inc_i (in_wait),
    .cnt_o (wait_cnt),
    .sat_o (wait_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      instr_q <= NOP_INSN;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          // dstall freezes everything and masks cstall for this cycle
          if (!IF_ID_dstall) begin
            pc_q <= pc_in;
            if (IF_ID_cstall) begin
              instr_q <= NOP_INSN;
              valid_q <= 1'b0;
              state_q <= ST_WAIT;
            end else begin
              instr_q <= fetch_valid ? instr_in : NOP_INSN;
              valid_q <= fetch_valid;
            end
          end
        end
        ST_WAIT: begin
          instr_q <= NOP_INSN;
          valid_q <= 1'b0;
          if (br_resolved || wait_sat) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_q + XLEN'(4);
  assign instr_out    = instr_q;
  assign valid_out    = valid_q;
  assign fetch_hold   = in_wait || IF_ID_dstall;

`ifdef IF_ID_PERF_CNT_EN
  logic unused_perf_sat;

  if_id_wait_ctr #(
    .W   (PERF_W),
    .MAX ({PERF_W{1'b1}})
  ) u_perf_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (in_wait),
    .cnt_o (bubble_total),
    .sat_o (unused_perf_sat)
  );
`endif

endmodule
